// File: rtl/ones_counter_accum.sv
// Windowed popcount: per-sample ones/zeros count in stage 1, accumulated over
// WINDOW accepted samples in stage 2, emitting the window total and a majority flag.
module ones_counter_accum #(
   parameter  int N      = 3,
   parameter  int WINDOW = 4,
   parameter  int MODE   = 0,
   localparam int CNT_W  = $clog2(N + 1),
   localparam int ACC_W  = $clog2(N * WINDOW + 1),
   localparam int IDX_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     in_bits,
   input  logic             in_valid,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic             count_valid,
   output logic [IDX_W-1:0] fill,
   output logic [ACC_W-1:0] total,
   output logic             total_valid,
   output logic             majority
);

   localparam logic             INV    = (MODE != 0);
   localparam logic [IDX_W-1:0] LAST   = IDX_W'(WINDOW - 1);
   localparam logic [ACC_W:0]   THRESH = (ACC_W + 1)'(N * WINDOW);

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] pop;
   logic [ACC_W-1:0] sum;
   logic [ACC_W:0]   sum_x2;
   logic             maj_next;

   // Zeros are counted by inverting each bit before the popcount.
   always_comb begin
      pop = '0;
      for (int i = 0; i < N; i++) begin
         pop = pop + CNT_W'(in_bits[i] ^ INV);
      end
   end

   assign sum      = acc + ACC_W'(count);
   assign sum_x2   = {sum, 1'b0};
   assign maj_next = (sum_x2 > THRESH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         count_valid <= 1'b0;
         fill        <= '0;
         total       <= '0;
         total_valid <= 1'b0;
         majority    <= 1'b0;
         acc         <= '0;
      end else if (clear) begin
         // The in-flight stage-1 sample is dropped along with the window;
         // count/total/majority keep their last values.
         count_valid <= 1'b0;
         total_valid <= 1'b0;
         acc         <= '0;
         fill        <= '0;
      end else begin
         if (in_valid) begin
            count       <= pop;
            count_valid <= 1'b1;
         end else begin
            count_valid <= 1'b0;
         end

         if (count_valid) begin
            if (fill == LAST) begin
               total       <= sum;
               majority    <= maj_next;
               total_valid <= 1'b1;
               acc         <= '0;
               fill        <= '0;
            end else begin
               acc         <= sum;
               fill        <= fill + IDX_W'(1);
               total_valid <= 1'b0;
            end
         end else begin
            total_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ones_counter_accum.sv
// Bench for ones_counter_accum: scoreboarded N=3/WINDOW=4 ones-count instance
// plus a directed N=8/WINDOW=1 zeros-count instance.
module tb_ones_counter_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: N=3, WINDOW=4, MODE=0
   logic       rst_a, vld_a, clr_a;
   logic [2:0] bits_a;
   logic [1:0] count_a;
   logic       cv_a, tv_a, maj_a;
   logic [1:0] fill_a;
   logic [3:0] total_a;

   // Instance B: N=8, WINDOW=1, MODE=1
   logic       rst_b, vld_b, clr_b;
   logic [7:0] bits_b;
   logic [3:0] count_b;
   logic       cv_b, tv_b, maj_b;
   logic [0:0] fill_b;
   logic [3:0] total_b;

   ones_counter_accum #(.N(3), .WINDOW(4), .MODE(0)) dut_a (
      .clk(clk), .rst(rst_a), .in_bits(bits_a), .in_valid(vld_a), .clear(clr_a),
      .count(count_a), .count_valid(cv_a), .fill(fill_a), .total(total_a),
      .total_valid(tv_a), .majority(maj_a));

   ones_counter_accum #(.N(8), .WINDOW(1), .MODE(1)) dut_b (
      .clk(clk), .rst(rst_b), .in_bits(bits_b), .in_valid(vld_b), .clear(clr_b),
      .count(count_b), .count_valid(cv_b), .fill(fill_b), .total(total_b),
      .total_valid(tv_b), .majority(maj_b));

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int val;
      int maj;
      int cyc;
   } exp_t;

   exp_t cq[$];
   exp_t tq[$];

   int m_acc, m_fill, m_pend;
   bit m_pend_vld;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard monitor: each queue entry names the cycle its pulse must appear in.
   always @(negedge clk) begin
      if (mon_en && !rst_a) begin
         automatic bit ce = (cq.size() > 0) && (cq[0].cyc == cyc);
         automatic bit te = (tq.size() > 0) && (tq[0].cyc == cyc);
         check("count_valid", int'(cv_a), int'(ce));
         if (ce) begin
            if (cv_a) check("count", int'(count_a), cq[0].val);
            void'(cq.pop_front());
         end
         check("total_valid", int'(tv_a), int'(te));
         if (te) begin
            if (tv_a) begin
               check("total", int'(total_a), tq[0].val);
               check("majority", int'(maj_a), tq[0].maj);
            end
            void'(tq.pop_front());
         end
      end
   end

   task automatic model_reset();
      m_acc = 0; m_fill = 0; m_pend = 0; m_pend_vld = 1'b0;
      cq.delete();
      tq.delete();
   endtask

   // One cycle of stimulus on instance A, with the expected effect of that edge.
   task automatic step(input bit v, input logic [2:0] b, input bit c);
      int p;
      @(negedge clk);
      vld_a = v; bits_a = b; clr_a = c;
      p = $countones(b);
      if (c) begin
         m_acc = 0; m_fill = 0; m_pend_vld = 1'b0;
      end else begin
         if (m_pend_vld) begin
            if (m_fill == 3) begin
               tq.push_back('{m_acc + m_pend, int'(2 * (m_acc + m_pend) > 12), cyc + 1});
               m_acc = 0; m_fill = 0;
            end else begin
               m_acc += m_pend; m_fill++;
            end
         end
         m_pend_vld = v;
         m_pend     = p;
         if (v) cq.push_back('{p, 0, cyc + 1});
      end
      @(posedge clk);
      #1;
      check("fill", int'(fill_a), m_fill);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0);
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, "_count"}, int'(count_a), 0);
      check({tag, "_cv"}, int'(cv_a), 0);
      check({tag, "_fill"}, int'(fill_a), 0);
      check({tag, "_total"}, int'(total_a), 0);
      check({tag, "_tv"}, int'(tv_a), 0);
      check({tag, "_maj"}, int'(maj_a), 0);
   endtask

   // Asserts reset between edges and checks outputs before any further edge.
   task automatic async_reset_a(input string tag);
      rst_a = 1'b1;
      #1;
      check_reset_a(tag);
      model_reset();
      @(negedge clk);
      vld_a = 1'b0; clr_a = 1'b0; bits_a = '0;
      @(negedge clk);
      rst_a = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      vld_a = 1'b0; clr_a = 1'b0; bits_a = '0;
      vld_b = 1'b0; clr_b = 1'b0; bits_b = '0;
      model_reset();
      #12;
      check_reset_a("init");
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;
      mon_en = 1'b1;

      // First sample after reset, then a mid-stream async reset
      step(1'b1, 3'b101, 1'b0);
      step(1'b1, 3'b111, 1'b0);
      step(1'b1, 3'b110, 1'b0);
      async_reset_a("rst_mid");

      // Full window at full rate
      step(1'b1, 3'b111, 1'b0);
      step(1'b1, 3'b110, 1'b0);
      step(1'b1, 3'b000, 1'b0);
      step(1'b1, 3'b011, 1'b0);
      idle(3);

      // Same samples with idle gaps 0, 3, 1
      step(1'b1, 3'b111, 1'b0);
      step(1'b1, 3'b110, 1'b0);
      idle(3);
      step(1'b1, 3'b000, 1'b0);
      idle(1);
      step(1'b1, 3'b011, 1'b0);
      idle(3);

      // Clear discards the partial window and the in-flight sample
      step(1'b1, 3'b111, 1'b0);
      step(1'b1, 3'b111, 1'b0);
      step(1'b1, 3'b111, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 3'b001, 1'b0);
      idle(3);

      // Back-to-back windows
      for (int i = 0; i < 8; i++) step(1'b1, 3'b111, 1'b0);
      idle(2);
      async_reset_a("rst_end");
      idle(2);

      check("cq_drained", cq.size(), 0);
      check("tq_drained", tq.size(), 0);

      // Instance B: zeros count, one-sample window
      @(negedge clk);
      vld_b = 1'b1; bits_b = 8'h0F;
      @(negedge clk);
      bits_b = 8'h00;
      check("b_count0", int'(count_b), 4);
      check("b_cv0", int'(cv_b), 1);
      check("b_tv0", int'(tv_b), 0);
      check("b_fill0", int'(fill_b), 0);
      @(negedge clk);
      vld_b = 1'b0;
      check("b_count1", int'(count_b), 8);
      check("b_cv1", int'(cv_b), 1);
      check("b_tv1", int'(tv_b), 1);
      check("b_total1", int'(total_b), 4);
      check("b_maj1", int'(maj_b), 0);
      @(negedge clk);
      check("b_tv2", int'(tv_b), 1);
      check("b_total2", int'(total_b), 8);
      check("b_maj2", int'(maj_b), 1);
      check("b_cv2", int'(cv_b), 0);
      rst_b = 1'b1;
      #1;
      check("b_rst_tv", int'(tv_b), 0);
      check("b_rst_total", int'(total_b), 0);
      check("b_rst_maj", int'(maj_b), 0);
      @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
